// File: rtl/mem_access_unit.sv
// Data-memory access unit between the core's memory stage and a synchronous RAM.
// Stores are posted in one cycle; loads stall the core until RAM data returns.
module mem_access_unit #(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                          clka,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic                          req_we,
  input  logic [1:0]                    req_size,
  input  logic                          req_signed,
  input  logic [AW-1:0]                 req_addr,
  input  logic [DW-1:0]                 req_wdata,
  output logic                          stall,
  output logic [DW-1:0]                 rdata,
  output logic                          rdata_valid,
  output logic                          addr_err,
  output logic                          ram_ena,
  output logic [DW/8-1:0]               ram_wea,
  output logic [AW-$clog2(DW/8)-1:0]    ram_addr,
  output logic [DW-1:0]                 ram_wdata,
  input  logic [DW-1:0]                 ram_rdata
);

  localparam int NL = DW / 8;
  localparam int OW = $clog2(NL);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic int size_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return 32'sd1;
      2'd1:    return 32'sd2;
      2'd2:    return 32'sd4;
      default: return 32'sd8;
    endcase
  endfunction

  // Dword on a 32-bit bus can never be satisfied, so it is reported as misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [OW-1:0] off);
    int nb;
    nb = size_bytes(size);
    if (nb > NL) begin
      return 1'b1;
    end else begin
      return (int'(off) % nb) != 32'sd0;
    end
  endfunction

  function automatic logic [NL-1:0] lane_mask(input logic [1:0] size, input logic [OW-1:0] off);
    logic [NL-1:0] m;
    int nb;
    nb = size_bytes(size);
    for (int i = 0; i < NL; i++) begin
      m[i] = (i < nb) ? 1'b1 : 1'b0;
    end
    return m << off;
  endfunction

  function automatic logic [DW-1:0] replicate(input logic [1:0] size, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    int nb;
    nb = (size_bytes(size) > NL) ? NL : size_bytes(size);
    for (int i = 0; i < NL; i++) begin
      r[i*8 +: 8] = d[(i % nb)*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] raw, input logic [OW-1:0] off,
                                                input logic [1:0] size, input logic sgn);
    logic [DW-1:0] sh;
    logic [DW-1:0] r;
    logic          fill;
    int            nbits;
    sh    = raw >> {off, 3'b000};
    nbits = (size_bytes(size) * 8 > DW) ? DW : size_bytes(size) * 8;
    fill  = sgn & sh[nbits-1];
    for (int i = 0; i < DW; i++) begin
      r[i] = (i < nbits) ? sh[i] : fill;
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [OW-1:0]   off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rdata_valid_q, rdata_valid_d;
  logic            addr_err_q, addr_err_d;

  logic            stall_s;
  logic            ram_ena_s;
  logic [NL-1:0]   ram_wea_s;
  logic [DW-1:0]   ram_wdata_s;
  logic [OW-1:0]   off_s;

  assign off_s = req_addr[OW-1:0];

  // State, load context and registered result outputs.
  always_ff @(posedge clka) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      off_q         <= '0;
      size_q        <= 2'd0;
      sgn_q         <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      off_q         <= off_d;
      size_q        <= size_d;
      sgn_q         <= sgn_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // Next-state and RAM-side outputs; RAM strobes are held off while in reset.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    off_d         = off_q;
    size_d        = size_q;
    sgn_d         = sgn_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    addr_err_d    = 1'b0;
    stall_s       = 1'b0;
    ram_ena_s     = 1'b0;
    ram_wea_s     = '0;
    ram_wdata_s   = '0;
    if (rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (misaligned(req_size, off_s)) begin
              addr_err_d = 1'b1;
            end else if (req_we) begin
              ram_ena_s   = 1'b1;
              ram_wea_s   = lane_mask(req_size, off_s);
              ram_wdata_s = replicate(req_size, req_wdata);
            end else begin
              ram_ena_s = 1'b1;
              stall_s   = 1'b1;
              off_d     = off_s;
              size_d    = req_size;
              sgn_d     = req_signed;
              cnt_d     = 3'(RD_LAT);
              state_d   = WAIT;
            end
          end else begin
            state_d = IDLE;
          end
        end
        WAIT: begin
          stall_s = 1'b1;
          if (cnt_q <= 3'd1) begin
            rdata_d       = load_extend(ram_rdata, off_q, size_q, sgn_q);
            rdata_valid_d = 1'b1;
            cnt_d         = 3'd0;
            state_d       = IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign stall       = stall_s;
  assign ram_ena     = ram_ena_s;
  assign ram_wea     = ram_wea_s;
  assign ram_wdata   = ram_wdata_s;
  assign ram_addr    = req_addr[AW-1:OW];
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign addr_err    = addr_err_q;

endmodule
